// File: rtl/mem_responder.sv
// Data-side memory responder: byte-enabled word RAM plus an optional down-counter timer.
// The timer, its register window and nIRQ are built only when MEM_RESPONDER_TIMER_EN is defined.
module mem_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memaddr,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [3:0]  be,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        nIRQ
);

   logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] widx;
   logic                  tsel;
   logic [31:0]           ram_rd;
   logic [31:0]           rd_word;

   assign widx   = memaddr[ADDR_WIDTH+1:2];
   assign ram_rd = mem[widx];

   // RAM is deliberately not reset; contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (memwrite && !tsel) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[widx][8*i +: 8] <= writedata[8*i +: 8];
      end
   end

   assign readdata = (reset && memread) ? rd_word : 32'd0;

`ifdef MEM_RESPONDER_TIMER_EN
   typedef enum logic {IDLE, RUN} tstate_e;

   tstate_e     state, state_nxt;
   logic        ie, ie_nxt, auto_rl, auto_nxt, pend, pend_nxt, nirq_q;
   logic [31:0] load, load_nxt, count, count_nxt, treg;
   logic        twr, wr_ctrl;
   logic [1:0]  off;

   assign tsel    = (memaddr[31:4] == TIMER_BASE[31:4]);
   assign off     = memaddr[3:2];
   assign twr     = memwrite && tsel;
   assign wr_ctrl = twr && (off == 2'd0) && be[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ie      <= 1'b0;
         auto_rl <= 1'b0;
         pend    <= 1'b0;
         load    <= 32'd0;
         count   <= 32'd0;
         nirq_q  <= 1'b1;
      end else begin
         state   <= state_nxt;
         ie      <= ie_nxt;
         auto_rl <= auto_nxt;
         pend    <= pend_nxt;
         load    <= load_nxt;
         count   <= count_nxt;
         nirq_q  <= ~(pend & ie);
      end
   end

   always_comb begin
      state_nxt = state;
      ie_nxt    = ie;
      auto_nxt  = auto_rl;
      pend_nxt  = pend;
      load_nxt  = load;
      count_nxt = count;
      if (wr_ctrl) begin
         ie_nxt   = writedata[1];
         auto_nxt = writedata[2];
      end
      if (twr && off == 2'd1) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) load_nxt[8*i +: 8] = writedata[8*i +: 8];
      end
      if (twr && off == 2'd3 && be[0] && writedata[0]) pend_nxt = 1'b0;
      // Expiry below overrides the W1C above; reloads read the pre-write LOAD.
      case (state)
         IDLE: begin
            if (wr_ctrl && writedata[0]) begin
               state_nxt = RUN;
               count_nxt = load;
            end
         end
         RUN: begin
            if (wr_ctrl && !writedata[0]) begin
               state_nxt = IDLE;
            end else if (count != 32'd0) begin
               count_nxt = count - 32'd1;
            end else begin
               pend_nxt = 1'b1;
               if (auto_rl) count_nxt = load;
               else         state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      treg = 32'd0;
      case (off)
         2'd0: treg = {29'd0, auto_rl, ie, (state == RUN)};
         2'd1: treg = load;
         2'd2: treg = count;
         2'd3: treg = {31'd0, pend};
         default: treg = 32'd0;
      endcase
   end

   assign rd_word = tsel ? treg : ram_rd;
   assign nIRQ    = nirq_q;
`else
   assign tsel    = 1'b0;
   assign rd_word = ram_rd;
   assign nIRQ    = 1'b1;
`endif

   logic unused_ok;
   assign unused_ok = ^{memaddr[1:0], memaddr[31:ADDR_WIDTH+2], TIMER_BASE};

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-side memory responder for the single-cycle ARM core. It serves the core's `memaddr`/`memwrite`/`memread`/`be`/`writedata`/`readdata` bus with a byte-enabled word RAM and a memory-mapped down-counter timer. The timer drives the core's active-low `nIRQ` input. The block sits beside the core in the top level as the far end of the core's data-memory interface.

## Interface
- `ADDR_WIDTH`, 10: RAM word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words (4 KiB at default).
- `TIMER_BASE`, 32'hFFFF_0000: byte address of the timer register window; the window is 16 bytes, aligned to 16.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memaddr` in 32: byte address from the core; bits [1:0] are ignored.
- `memwrite` in 1: write strobe, sampled at rising edge.
- `memread` in 1: read enable.
- `be` in 4: byte enables; `be[i]` covers `writedata[8i+7:8i]`.
- `writedata` in 32: store data.
- `readdata` out 32: load data, combinational from the current address.
- `nIRQ` out 1: active-low interrupt request to the core, registered.

## Operation
- Decode:
  - `memaddr[31:4] == TIMER_BASE[31:4]` selects the timer window.
  - Every other address selects RAM at word index `memaddr[ADDR_WIDTH+1:2]`. Addresses above the RAM size alias modulo the RAM size.
- RAM write: at a rising edge with `memwrite=1`, each byte lane with `be[i]=1` is updated. Lanes with `be[i]=0` are unchanged. `be=0000` writes nothing.
- RAM read: `readdata` shows the addressed word combinationally, with all four bytes regardless of `be`. The core samples it within the same cycle.
- `readdata = 0` whenever `memread=0` or `reset=0`.
- Timer registers (word offset = `memaddr[3:2]`):
  - 0 CTRL, RW: bit0 EN, bit1 IE, bit2 AUTO. Bits [31:3] read 0.
  - 1 LOAD, RW, 32-bit.
  - 2 COUNT, RO; writes ignored.
  - 3 STATUS: bit0 PEND. Write 1 clears PEND; write 0 has no effect.
- Timer writes honour `be` per byte. CTRL and STATUS act on byte 0 only.
- Timer state machine (IDLE/RUN):
  - IDLE: EN=0; COUNT holds.
  - A CTRL write that takes EN from 0 to 1 loads COUNT←LOAD (the value written to LOAD in earlier cycles) and enters RUN.
  - RUN, COUNT≠0: COUNT decrements by 1 each cycle.
  - RUN, COUNT==0: PEND←1 (expiry). Then:
    - AUTO=1: COUNT←LOAD, stay in RUN.
    - AUTO=0: EN←0, go to IDLE, COUNT stays 0.
  - Writing EN=0 in RUN stops the timer at once; COUNT freezes.
- `nIRQ` next value is `~(PEND & IE)`.
- Boundary rules:
  - LOAD=0 with AUTO=1: expiry occurs every cycle.
  - Expiry in the same cycle as a STATUS W1C: the set wins, PEND=1.
  - LOAD written in the same cycle as an expiry reload: the reload uses the old LOAD.
  - A CTRL write with EN=1 while already running does not reload.
  - Reset asserted mid-count: the timer returns to reset values immediately.

## Timing
- Reset values: CTRL=0, LOAD=0, COUNT=0, PEND=0, state IDLE, `nIRQ=1`, `readdata=0`. RAM contents are not reset (undefined).
- Read latency: 0 cycles, combinational.
- Write takes effect at the rising edge where `memwrite=1`. A read of the same address in the next cycle returns the new data.
- Timer latency:
  - With LOAD=N written and EN set at edge k: COUNT=N after edge k, reaches 0 after edge k+N, PEND=1 after edge k+N+1.
  - `nIRQ` falls at edge k+N+2 when IE=1.
- Clearing PEND at edge j raises `nIRQ` at edge j+1.
- Clearing IE at edge j raises `nIRQ` at edge j+1; PEND is retained.

## Configuration
- `MEM_RESPONDER_TIMER_EN` defined: the timer, its register window and its `nIRQ` logic are built as described above.
- Not defined:
  - No timer logic is built.
  - `nIRQ` is tied to 1.
  - The TIMER_BASE window decodes as ordinary RAM (aliased); no address is special.

## Test plan
- Byte-lane writes: write 0xAABBCCDD to address 0x10 with `be=1111`, then write 0x11223344 with `be=0101` → reading 0x10 returns 0xAA22CC44.
- Aliasing and memread: with ADDR_WIDTH=10, write 0x12345678 to 0x0000_0004 → reading 0x0000_1004 returns 0x12345678; the same read with `memread=0` returns 0.
- One-shot timer: LOAD=3, then CTRL=0b011 → COUNT goes 3,2,1,0; PEND=1 one cycle after COUNT reaches 0; `nIRQ` low on the following edge; EN reads 0; COUNT stays 0.
- Auto-reload with clear: LOAD=2, CTRL=0b111 → PEND sets every 3 cycles; W1C to STATUS in the same cycle as an expiry leaves PEND=1 and `nIRQ` low.
- Reset mid-operation: drop `reset` to 0 while COUNT=5 in RUN → `nIRQ=1`, `readdata=0` and CTRL/LOAD/COUNT read 0 after release; a RAM word written before reset still reads back its written value.
- Macro off: build without `MEM_RESPONDER_TIMER_EN` → `nIRQ` stays 1; writing 0xDEADBEEF to TIMER_BASE+4 and reading it back returns 0xDEADBEEF from RAM.
